// File: rtl/debounce_event_ctrl.sv
// debounce_event_ctrl: multi-channel synchroniser + debouncer with press/release
// pulses, sticky per-channel event flags and a registered IRQ.
// Optional long-press detection is built when the macro DEBOUNCE_LONGPRESS_EN is
// defined; without it long_pulse is tied to 0 and only presses set event_pending.
module debounce_event_ctrl #(
    parameter int    WIDTH         = 2,
    parameter string POLARITY      = "LOW",
    parameter int    TIMEOUT       = 50000,
    parameter int    TIMEOUT_WIDTH = 16,
    parameter int    SYNC_STAGES   = 2,
    parameter int    LONG_TICKS    = 1000,
    parameter int    LONG_WIDTH    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] event_pending,
    output logic             irq
);

    // Active level of the pins; the idle (reset) level is its complement.
    localparam logic                     ACTIVE   = (POLARITY == "HIGH") ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0]         IDLE_LVL = {WIDTH{~ACTIVE}};
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    // Reject parameter sets the counters cannot represent.
    if (TIMEOUT < 2 || SYNC_STAGES < 2 || (64'(1) << TIMEOUT_WIDTH) < 64'(TIMEOUT) ||
        LONG_TICKS < 1 || (64'(1) << LONG_WIDTH) <= 64'(LONG_TICKS)) begin : g_param_check
        $error("debounce_event_ctrl: illegal parameter combination");
    end

    logic [WIDTH-1:0]         sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]         s;
    logic [TIMEOUT_WIDTH-1:0] cnt_q  [WIDTH];
    logic [TIMEOUT_WIDTH-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0]         data_q, data_d;
    logic [WIDTH-1:0]         press_q, press_d;
    logic [WIDTH-1:0]         release_q, release_d;
    logic [WIDTH-1:0]         pend_q, pend_d;
    logic                     irq_q;

    // Input synchroniser chain; s is the metastability-safe view of the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE_LVL;
        end else begin
            sync_q[0] <= data_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-channel stability counter: any return to the current level restarts it,
    // TIMEOUT consecutive differing samples commit the new level and fire an edge pulse.
    always_comb begin
        data_d    = data_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != data_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    data_d[i] = s[i];
                    if (s[i] == ACTIVE) press_d[i]   = 1'b1;
                    else                release_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level, counters and edge pulses are all registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            data_q    <= IDLE_LVL;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            data_q    <= data_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [LONG_WIDTH-1:0] LONG_MAX  = LONG_WIDTH'(LONG_TICKS);
    localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_TICKS - 1);

    logic [TIMEOUT_WIDTH-1:0] pre_q;
    logic                     tick;
    logic [LONG_WIDTH-1:0]    lcnt_q [WIDTH];
    logic [WIDTH-1:0]         long_q;

    assign tick = (pre_q == CNT_LAST);

    // Shared free-running prescaler: one tick every TIMEOUT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pre_q <= '0;
        else          pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    // Hold-time counter per channel; saturates so the long pulse fires once per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) lcnt_q[i] <= '0;
            long_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                long_q[i] <= 1'b0;
                if (data_q[i] != ACTIVE) begin
                    lcnt_q[i] <= '0;
                end else if (tick && lcnt_q[i] != LONG_MAX) begin
                    lcnt_q[i] <= lcnt_q[i] + 1'b1;
                    long_q[i] <= (lcnt_q[i] == LONG_LAST);
                end
            end
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = '0;
`endif

    // Sticky event flags: a visible press/long pulse sets, event_clr clears, set wins.
    always_comb begin
        pend_d = (pend_q & ~event_clr) | press_q | long_pulse;
    end

    // Event flags and the IRQ summary; irq trails event_pending by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= |pend_q;
        end
    end

    assign data_out      = data_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign event_pending = pend_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Bench for debounce_event_ctrl (WIDTH=2, LOW polarity, TIMEOUT=8, LONG_TICKS=4).
module tb_debounce_event_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] data_in;
    logic [1:0] event_clr;
    logic [1:0] data_out, press_pulse, release_pulse, long_pulse, event_pending;
    logic       irq;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int long_seen = 0;
    int c;

    // Expected pulse events: {press, release, long, data_out} plus an allowed cycle window.
    logic [7:0] exp_q[$];
    int         exp_lo_q[$];
    int         exp_hi_q[$];

    logic [7:0] got, e;
    int         lo, hi;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_event_ctrl #(
        .WIDTH(2), .POLARITY("LOW"), .TIMEOUT(8), .TIMEOUT_WIDTH(4),
        .SYNC_STAGES(2), .LONG_TICKS(4), .LONG_WIDTH(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
        .event_clr(event_clr), .event_pending(event_pending), .irq(irq)
    );

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input logic [7:0] v, input int l, input int h);
        exp_q.push_back(v);
        exp_lo_q.push_back(l);
        exp_hi_q.push_back(h);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle with any pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (press_pulse | release_pulse | long_pulse) !== 2'b00) begin
            got = {press_pulse, release_pulse, long_pulse, data_out};
            if (long_pulse !== 2'b00) long_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual=%h required=none (cycle %0d)", got, cyc);
            end else begin
                e  = exp_q.pop_front();
                lo = exp_lo_q.pop_front();
                hi = exp_hi_q.pop_front();
                if (got !== e || cyc < lo || cyc > hi) begin
                    failures++;
                    $display("FAIL pulse_event actual=%h@%0d required=%h@%0d..%0d", got, cyc, e, lo, hi);
                end
            end
        end
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset_n   = 1'b0;
        data_in   = 2'b11;
        event_clr = 2'b00;

        // Reset values.
        wait_cyc(3);
        check("rst_data_out", 32'(data_out), 32'h3);
        check("rst_press", 32'(press_pulse), 32'h0);
        check("rst_release", 32'(release_pulse), 32'h0);
        check("rst_long", 32'(long_pulse), 32'h0);
        check("rst_pending", 32'(event_pending), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        wait_cyc(3);

        // Bounces of 7 cycles never reach the 8-cycle timeout.
        for (int r = 0; r < 5; r++) begin
            data_in[0] = 1'b0;
            wait_cyc(7);
            data_in[0] = 1'b1;
            wait_cyc(3);
        end
        wait_cyc(12);
        check("bounce_data_out", 32'(data_out), 32'h3);
        check("bounce_pending", 32'(event_pending), 32'h0);

        // Clean press on ch0: 10-cycle latency, pending next, irq after that.
        data_in = 2'b10;
        c = cyc;
        expect_evt({2'b01, 2'b00, 2'b00, 2'b10}, c + 10, c + 10);
        wait_cyc(9);
        check("latency_not_early", 32'(data_out), 32'h3);
        wait_cyc(1);
        check("press_data_out", 32'(data_out), 32'h2);
        check("pending_lags_pulse", 32'(event_pending), 32'h0);
        wait_cyc(1);
        check("pending_set", 32'(event_pending), 32'h1);
        check("irq_lags_pending", 32'(irq), 32'h0);
        wait_cyc(1);
        check("irq_set", 32'(irq), 32'h1);

        // Release on ch0.
        data_in = 2'b11;
        c = cyc;
        expect_evt({2'b00, 2'b01, 2'b00, 2'b11}, c + 10, c + 10);
        wait_cyc(9);
        check("release_not_early", 32'(data_out), 32'h2);
        wait_cyc(1);
        check("release_data_out", 32'(data_out), 32'h3);
        wait_cyc(2);
        check("release_keeps_pending", 32'(event_pending), 32'h1);

        // Clear alone: pending drops next cycle, irq one cycle later.
        event_clr = 2'b01;
        wait_cyc(1);
        event_clr = 2'b00;
        check("clr_pending", 32'(event_pending), 32'h0);
        check("clr_irq_lag", 32'(irq), 32'h1);
        wait_cyc(1);
        check("clr_irq", 32'(irq), 32'h0);

        // Clear in the same cycle as a new press pulse: set wins.
        data_in = 2'b10;
        c = cyc;
        expect_evt({2'b01, 2'b00, 2'b00, 2'b10}, c + 10, c + 10);
        wait_cyc(10);
        event_clr = 2'b01;
        wait_cyc(1);
        event_clr = 2'b00;
        check("set_wins", 32'(event_pending), 32'h1);
        event_clr = 2'b01;
        wait_cyc(1);
        event_clr = 2'b00;
        check("clr_after_set", 32'(event_pending), 32'h0);
        check("clr_after_set_irq_lag", 32'(irq), 32'h1);
        wait_cyc(1);
        check("clr_after_set_irq", 32'(irq), 32'h0);
        data_in = 2'b11;
        c = cyc;
        expect_evt({2'b00, 2'b01, 2'b00, 2'b11}, c + 10, c + 10);
        wait_cyc(12);
        check("ch0_released", 32'(data_out), 32'h3);

        // Both channels in the same cycle.
        data_in = 2'b00;
        c = cyc;
        expect_evt({2'b11, 2'b00, 2'b00, 2'b00}, c + 10, c + 10);
        wait_cyc(10);
        check("both_data_out", 32'(data_out), 32'h0);
        wait_cyc(1);
        check("both_pending", 32'(event_pending), 32'h3);
        data_in = 2'b11;
        c = cyc;
        expect_evt({2'b00, 2'b11, 2'b00, 2'b11}, c + 10, c + 10);
        wait_cyc(12);
        check("both_released", 32'(data_out), 32'h3);
        event_clr = 2'b11;
        wait_cyc(1);
        event_clr = 2'b00;
        wait_cyc(1);
        check("both_cleared", 32'(event_pending), 32'h0);
        check("both_cleared_irq", 32'(irq), 32'h0);

        // Long hold on ch1 for 40 cycles.
        data_in = 2'b01;
        c = cyc;
        expect_evt({2'b10, 2'b00, 2'b00, 2'b01}, c + 10, c + 10);
`ifdef DEBOUNCE_LONGPRESS_EN
        expect_evt({2'b00, 2'b00, 2'b10, 2'b01}, c + 34, c + 42);
`endif
        wait_cyc(12);
        event_clr = 2'b10;
        wait_cyc(1);
        event_clr = 2'b00;
        check("hold_pending_cleared", 32'(event_pending), 32'h0);
        wait_cyc(27);
        data_in = 2'b11;
        c = cyc;
        expect_evt({2'b00, 2'b10, 2'b00, 2'b11}, c + 10, c + 10);
        wait_cyc(12);
`ifdef DEBOUNCE_LONGPRESS_EN
        check("long_count", 32'(long_seen), 32'd1);
        check("long_sets_pending", 32'(event_pending), 32'h2);
`else
        check("long_count", 32'(long_seen), 32'd0);
        check("no_long_pending", 32'(event_pending), 32'h0);
`endif
        event_clr = 2'b11;
        wait_cyc(1);
        event_clr = 2'b00;

        // Asynchronous reset mid-run takes effect before the next clock edge.
        data_in = 2'b10;
        c = cyc;
        expect_evt({2'b01, 2'b00, 2'b00, 2'b10}, c + 10, c + 10);
        wait_cyc(12);
        check("pre_reset_data_out", 32'(data_out), 32'h2);
        check("pre_reset_pending", 32'(event_pending), 32'h1);
        check("pre_reset_irq", 32'(irq), 32'h1);
        #2;
        reset_n = 1'b0;
        data_in = 2'b11;
        #1;
        check("async_rst_data_out", 32'(data_out), 32'h3);
        check("async_rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'h0);
        check("async_rst_pending", 32'(event_pending), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(15);
        check("post_reset_data_out", 32'(data_out), 32'h3);
        check("post_reset_pending", 32'(event_pending), 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
